muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width; SHALL support any even value 8..64.
REQ-002 clk  input  1  clock; all state SHALL update on rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-006 a, b  input  WIDTH each  operands (dividend/divisor for div).
REQ-007 hi_we, lo_we  input  1 each  direct writes (mthi/mtlo).
REQ-008 wd  input  WIDTH  direct write data.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 done  output  1  one-cycle pulse when hi/lo take a new result.
REQ-011 hi, lo  output  WIDTH each  registered result registers.
REQ-012 divzero  output  1  present only with MULDIV_DIVZERO_EN; pulses with done when a div/divu had b==0.

Function
REQ-013 FSM states: IDLE, CALC, FIX; busy=1 in CALC and FIX only.
REQ-014 IDLE and start=1 at an edge: latch op, |a|, |b| (signed ops) or a, b (unsigned ops), operand signs; load counter=WIDTH; go to CALC.
REQ-015 CALC: one radix-2 step per edge (shift-add multiply / restoring divide on unsigned magnitudes); counter decrements; after WIDTH steps go to FIX.
REQ-016 FIX: one edge applies sign correction, writes hi/lo, sets done=1 for the next cycle, returns to IDLE.
REQ-017 Latency: start sampled at edge 0 -> hi/lo valid and done=1 after edge WIDTH+1; busy=1 from after edge 0 until edge WIDTH+1.
REQ-018 Multiply: {hi,lo} = full 2*WIDTH-bit product; signed product negated when sign(a)^sign(b).
REQ-019 Divide: lo=quotient truncated toward zero, hi=remainder; quotient sign = sign(a)^sign(b); remainder sign = sign(a).
REQ-020 Signed overflow: most-negative / -1 SHALL give lo=most-negative, hi=0.
REQ-021 b==0 on div or divu SHALL give hi=a, lo=all ones, irrespective of sign.
REQ-022 start while busy=1 SHALL be ignored; no queueing.
REQ-023 start in the same cycle as done=1 SHALL be accepted (state is IDLE).
REQ-024 hi_we/lo_we in IDLE SHALL write wd next edge; while busy they SHALL be ignored.
REQ-025 hi_we with start in IDLE: write takes effect; the later result overwrites it.
REQ-026 hi/lo SHALL hold their value between writes; intermediate CALC state SHALL never be visible on hi/lo.

Reset
REQ-027 reset=1 at an edge, in any state including mid-CALC: state=IDLE, hi=0, lo=0, busy=0, done=0, divzero=0, counter=0; in-flight op discarded.
REQ-028 reset SHALL take priority over start, hi_we and lo_we at the same edge.

Configuration
REQ-029 Macro MULDIV_DIVZERO_EN: when defined, div/divu with b==0 skips CALC; start at edge 0 -> FIX at edge 1 writes REQ-021 values, done=1 and divzero=1 after edge 1; the divzero port exists.
REQ-030 Without MULDIV_DIVZERO_EN: divzero port absent; b==0 takes full WIDTH+1 latency and still yields REQ-021 values.

Verification
REQ-031 WIDTH=32, mult a=7, b=0xFFFFFFFD -> after edge 33: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle.
REQ-032 multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; start pulsed at edge 5 while busy ignored (result unchanged, latency unchanged).
REQ-033 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 divu a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF; with macro done+divzero after edge 1, without macro done after edge 33.
REQ-035 Mid-op reset: divu started, reset at edge 10 -> busy=0, hi=lo=0, no done pulse; new start at edge 12 completes normally after edge 45.
REQ-036 Back-to-back: start held high through done -> second op accepted in the done cycle; hi_we=1, wd=0xA5A5A5A5 while busy -> hi unaffected; same in IDLE -> hi=0xA5A5A5A5 next edge.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per clock: shift-add multiply or restoring divide on
// unsigned magnitudes, followed by a single sign-correction (FIX) cycle.
// Optional feature macro: MULDIV_DIVZERO_EN -- adds the divzero output and a
// fast path that skips the iterative phase for a divide by zero.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_EN
   ,
   output logic             divzero
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t           state_q, state_d;
   logic             is_div_q, is_div_d;   // op[1]: divide family
   logic             neg_q, neg_d;         // product / quotient sign
   logic             aneg_q, aneg_d;       // remainder sign (sign of dividend)
   logic             bzero_q, bzero_d;     // divide with zero divisor
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mag_q, mag_d;         // multiplicand or divisor magnitude
   logic [WIDTH-1:0] whi_q, whi_d;         // partial product high / remainder
   logic [WIDTH-1:0] wlo_q, wlo_d;         // multiplier bits / dividend-quotient
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
`ifdef MULDIV_DIVZERO_EN
   logic             dz_q, dz_d;
`endif

   // Operand sign handling: only the signed ops (op[0]==0) look at the MSB.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;

   // One multiply step: conditionally add, then shift {whi,wlo} right.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi, mul_lo;

   // One restoring divide step: shift in the next dividend bit, try subtract.
   // The trial remainder needs one extra bit; the kept remainder never does.
   logic [WIDTH:0]   div_tmp;
   logic [WIDTH-1:0] div_sub, div_hi, div_lo;
   logic             div_ok;

   // Sign correction applied in the FIX cycle.
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // Datapath arithmetic shared by the next-state logic.
   always_comb begin
      a_neg    = ~op[0] & a[WIDTH-1];
      b_neg    = ~op[0] & b[WIDTH-1];
      a_abs    = a_neg ? -a : a;
      b_abs    = b_neg ? -b : b;

      mul_sum  = {1'b0, whi_q} + {1'b0, mag_q};
      mul_hi   = wlo_q[0] ? mul_sum[WIDTH:1] : {1'b0, whi_q[WIDTH-1:1]};
      mul_lo   = {(wlo_q[0] ? mul_sum[0] : whi_q[0]), wlo_q[WIDTH-1:1]};

      div_tmp  = {whi_q, wlo_q[WIDTH-1]};
      div_ok   = (div_tmp >= {1'b0, mag_q});
      div_sub  = div_tmp[WIDTH-1:0] - mag_q;
      div_hi   = div_ok ? div_sub : div_tmp[WIDTH-1:0];
      div_lo   = {wlo_q[WIDTH-2:0], div_ok};

      prod     = {whi_q, wlo_q};
      prod_fix = neg_q ? -prod : prod;
      quo_fix  = neg_q ? -wlo_q : wlo_q;
      rem_fix  = aneg_q ? -whi_q : whi_q;
   end

   // Next-state logic: FSM sequencing, iteration, result write-back.
   always_comb begin
      state_d  = state_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      aneg_d   = aneg_q;
      bzero_d  = bzero_q;
      cnt_d    = cnt_q;
      mag_d    = mag_q;
      whi_d    = whi_q;
      wlo_d    = wlo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_d     = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            // Direct writes land first; a result started now overwrites later.
            if (hi_we) hi_d = wd;
            if (lo_we) lo_d = wd;
            if (start) begin
               is_div_d = op[1];
               aneg_d   = a_neg;
               neg_d    = a_neg ^ b_neg;
               bzero_d  = op[1] & (b == '0);
               cnt_d    = CW'(WIDTH);
               whi_d    = '0;
               mag_d    = op[1] ? b_abs : a_abs;
               wlo_d    = op[1] ? a_abs : b_abs;
               state_d  = S_CALC;
`ifdef MULDIV_DIVZERO_EN
               // Zero divisor: the remainder is just |a|, so go straight to FIX.
               if (op[1] && (b == '0)) begin
                  whi_d   = a_abs;
                  cnt_d   = '0;
                  state_d = S_FIX;
               end
`endif
            end
         end
         S_CALC: begin
            whi_d = is_div_q ? div_hi : mul_hi;
            wlo_d = is_div_q ? div_lo : mul_lo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (is_div_q) begin
               // Remainder carries the dividend sign, so b==0 yields hi=a.
               hi_d = rem_fix;
               lo_d = bzero_q ? '1 : quo_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
`ifdef MULDIV_DIVZERO_EN
            dz_d    = is_div_q & bzero_q;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset; reset wins over any request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         aneg_q   <= 1'b0;
         bzero_q  <= 1'b0;
         cnt_q    <= '0;
         mag_q    <= '0;
         whi_q    <= '0;
         wlo_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
         dz_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         aneg_q   <= aneg_d;
         bzero_q  <= bzero_d;
         cnt_q    <= cnt_d;
         mag_q    <= mag_d;
         whi_q    <= whi_d;
         wlo_q    <= wlo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
`ifdef MULDIV_DIVZERO_EN
         dz_q     <= dz_d;
`endif
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
`ifdef MULDIV_DIVZERO_EN
   assign divzero = dz_q;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32). Expected {divzero,hi,lo}
// values are queued when an operation is issued and compared on done.
module tb_muldiv_unit;

   localparam int W = 32;
`ifdef MULDIV_DIVZERO_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, hi_we, lo_we;
   logic [1:0]    op;
   logic [W-1:0]  a, b, wd;
   logic          busy, done;
   logic [W-1:0]  hi, lo;
`ifdef MULDIV_DIVZERO_EN
   logic          divzero;
`endif

   int            checks = 0;
   int            errors = 0;
   logic [64:0]   exp_q[$];
   logic [64:0]   mon_e;
   logic [64:0]   b2b_e;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .hi_we  (hi_we),
      .lo_we  (lo_we),
      .wd     (wd),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
`ifdef MULDIV_DIVZERO_EN
      ,
      .divzero(divzero)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: {divzero, hi, lo}.
   function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint      p;
      logic [63:0] u;
      logic [31:0] q, r;
      case (o)
         2'd0: begin
            p = longint'($signed(x)) * longint'($signed(y));
            return {1'b0, 64'(p)};
         end
         2'd1: begin
            u = {32'b0, x} * {32'b0, y};
            return {1'b0, u};
         end
         default: begin
            if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
            if (o == 2'd2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
               return {1'b0, 32'h0, 32'h8000_0000};
            if (o == 2'd2) begin
               q = $signed(x) / $signed(y);
               r = $signed(x) % $signed(y);
            end else begin
               q = x / y;
               r = x % y;
            end
            return {1'b0, r, q};
         end
      endcase
   endfunction

   function automatic int lat(input logic [1:0] o, input logic [31:0] y);
      return (DZ_EN && o[1] && y == 32'd0) ? 1 : W + 1;
   endfunction

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done hi=%h lo=%h required no done", hi, lo);
         end else begin
            mon_e = exp_q.pop_front();
            if ({hi, lo} !== mon_e[63:0]) begin
               errors++;
               $display("FAIL result got hi=%h lo=%h required hi=%h lo=%h", hi, lo, mon_e[63:32], mon_e[31:0]);
            end else begin
               $display("result hi=%h lo=%h ok", hi, lo);
            end
`ifdef MULDIV_DIVZERO_EN
            checks++;
            if (divzero !== mon_e[64]) begin
               errors++;
               $display("FAIL divzero got %b required %b", divzero, mon_e[64]);
            end
`endif
         end
      end
   end

   task automatic drive_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      if (push) exp_q.push_back(model(o, x, y));
   endtask

   // Advance negedges until done is seen or the bound expires; c counts edges.
   task automatic wait_done(inout int c);
      do begin
         @(negedge clk);
         c++;
      end while (done !== 1'b1 && c < 200);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
      int c = 0;
      drive_start(o, x, y, 1'b1);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_busy got %b required 1", nm, busy);
      end
      wait_done(c);
      checks++;
      if (c != lat(o, y)) begin
         errors++;
         $display("FAIL %s_latency got %0d required %0d", nm, c, lat(o, y));
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_pulse got done=%b busy=%b required 0 0", nm, done, busy);
      end
      $display("op %s a=%h b=%h latency=%0d", nm, x, y, c);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'd0; a = '0; b = '0; wd = '0;
      repeat (3) @(negedge clk);
      // Reset must beat start and direct writes at the same edge.
      start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wd = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got busy=%b done=%b required 0 0", busy, done);
      end
      checks++;
      if (hi !== 32'h0 || lo !== 32'h0) begin
         errors++;
         $display("FAIL reset_hilo got hi=%h lo=%h required 0 0", hi, lo);
      end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; reset = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== 32'h0) begin
         errors++;
         $display("FAIL reset_release got busy=%b hi=%h required 0 0", busy, hi);
      end
      $display("reset done");
   endtask

   task automatic test_mult();
      run_op(2'd0, 32'd7, 32'hFFFF_FFFD, "mult_neg");
      run_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
      run_op(2'd1, 32'hDEAD_BEEF, 32'h0000_0000, "multu_zero");
   endtask

   task automatic test_busy_start();
      int c = 0;
      drive_start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         c++;
      end
      start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5;
      @(negedge clk);
      c++;
      start = 1'b0;
      wait_done(c);
      checks++;
      if (c != W + 1) begin
         errors++;
         $display("FAIL busy_start_latency got %0d required %0d", c, W + 1);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_queued got busy=%b required 0", busy);
      end
      $display("busy start ignored latency=%0d", c);
   endtask

   task automatic test_div();
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(2'd2, 32'd100, 32'hFFFF_FFF9, "div_negb");
      run_op(2'd3, 32'hFFFF_FFF9, 32'd2, "divu");
   endtask

   task automatic test_divzero();
      run_op(2'd3, 32'h1234_5678, 32'd0, "divu_zero");
      run_op(2'd2, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");
   endtask

   task automatic test_mid_reset();
      drive_start(2'd3, 32'd100, 32'd7, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset got busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo);
      end
      run_op(2'd3, 32'd1000, 32'd7, "after_reset");
   endtask

   task automatic test_back_to_back();
      int c = 0;
      drive_start(2'd0, 32'd3, 32'd4, 1'b1);
      @(negedge clk);
      // Second op presented while busy with start held; write attempt ignored.
      op = 2'd1; a = 32'hFFFF_0000; b = 32'h10;
      b2b_e = model(2'd1, 32'hFFFF_0000, 32'h10);
      exp_q.push_back(b2b_e);
      hi_we = 1'b1; wd = 32'hA5A5_A5A5;
      @(negedge clk);
      c++;
      hi_we = 1'b0;
      wait_done(c);
      checks++;
      if (c != W + 1) begin
         errors++;
         $display("FAIL b2b_first_latency got %0d required %0d", c, W + 1);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept got busy=%b done=%b required 1 0", busy, done);
      end
      c = 0;
      wait_done(c);
      checks++;
      if (c != W + 1) begin
         errors++;
         $display("FAIL b2b_second_latency got %0d required %0d", c, W + 1);
      end
      @(negedge clk);
      $display("back to back latency=%0d", c);
   endtask

   task automatic test_direct_write();
      int c = 0;
      @(negedge clk);
      hi_we = 1'b1; wd = 32'hA5A5_A5A5;
      @(negedge clk);
      hi_we = 1'b0;
      checks++;
      if (hi !== 32'hA5A5_A5A5 || lo !== b2b_e[31:0]) begin
         errors++;
         $display("FAIL mthi got hi=%h lo=%h required hi=a5a5a5a5 lo=%h", hi, lo, b2b_e[31:0]);
      end
      lo_we = 1'b1; wd = 32'h5A5A_1234;
      @(negedge clk);
      lo_we = 1'b0;
      checks++;
      if (hi !== 32'hA5A5_A5A5 || lo !== 32'h5A5A_1234) begin
         errors++;
         $display("FAIL mtlo got hi=%h lo=%h required hi=a5a5a5a5 lo=5a5a1234", hi, lo);
      end
      // Write together with start: write visible now, result overwrites later.
      drive_start(2'd1, 32'd2, 32'd3, 1'b1);
      hi_we = 1'b1; wd = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      checks++;
      if (hi !== 32'hDEAD_BEEF || busy !== 1'b1) begin
         errors++;
         $display("FAIL mthi_start got hi=%h busy=%b required deadbeef 1", hi, busy);
      end
      wait_done(c);
      checks++;
      if (c != W + 1) begin
         errors++;
         $display("FAIL mthi_start_latency got %0d required %0d", c, W + 1);
      end
      @(negedge clk);
      $display("direct writes done");
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [31:0] x, y;
      for (int i = 0; i < 24; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         if (i % 6 == 0) y = 32'd0;
         if (i % 5 == 2) y = y >> 20;
         run_op(o, x, y, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_busy_start();
      test_div();
      test_divzero();
      test_mid_reset();
      test_back_to_back();
      test_direct_write();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_results got %0d pending required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
